conditioned_shifter: RTL and testbench
======================================

CONDITIONED_SHIFTER -- requirements
Module: conditioned_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, shift register width (>=2).
REQ-002 SHALL have parameter WAIT, default 3, debounce stability window in clock cycles (>=1).
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port btn_load  input  1  raw asynchronous noisy load button.
REQ-006 SHALL have port sw_clk  input  1  raw asynchronous noisy shift-strobe switch.
REQ-007 SHALL have port sw_data  input  1  raw asynchronous noisy serial data switch.
REQ-008 SHALL have port mode  input  2  shift mode: 00 shift-left, 01 shift-right, 10 rotate-left, 11 rotate-right.
REQ-009 SHALL have port load_data  input  WIDTH  parallel load value.
REQ-010 SHALL have port parallelout  output  WIDTH  shift register contents.
REQ-011 SHALL have port serialout  output  1  outgoing serial bit.
REQ-012 SHALL have port bitcount  output  $clog2(WIDTH)  shifts since last load/frame.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse on frame completion.

Function
REQ-014 Each raw input SHALL pass through an independent two-flop synchronizer, then a debouncer.
REQ-015 Debouncer: per-input counter increments each cycle synchronized value != conditioned value, clears when equal; conditioned value SHALL flip on the edge the counter reaches WAIT, counter clears.
REQ-016 Synchronized mismatch lasting fewer than WAIT consecutive cycles SHALL not change the conditioned value.
REQ-017 Rising-edge pulse (load event for btn_load, shift event for sw_clk) SHALL be registered, high exactly one cycle, in the cycle after conditioned goes 0->1; falling edges produce no event.
REQ-018 Total latency: raw 0->1 sampled at edge N, stable thereafter -> event pulse high after edge N+WAIT+2, register updates at edge N+WAIT+3.
REQ-019 Load event SHALL set parallelout=load_data, bitcount=0.
REQ-020 Shift event, mode 00: parallelout={parallelout[WIDTH-2:0], conditioned sw_data}.
REQ-021 Shift event, mode 01: parallelout={conditioned sw_data, parallelout[WIDTH-1:1]}.
REQ-022 Shift event, mode 10: rotate left by one; mode 11: rotate right by one; sw_data ignored.
REQ-023 mode SHALL be sampled at the shift edge; changing mode mid-frame SHALL not affect bitcount.
REQ-024 serialout SHALL be combinational: parallelout[WIDTH-1] for modes 00/10, parallelout[0] for modes 01/11.
REQ-025 Each shift event SHALL increment bitcount; at WIDTH-1 it SHALL wrap to 0 and frame_done SHALL be high the following cycle for exactly one cycle.
REQ-026 Load and shift events in the same cycle: load SHALL win, shift discarded, bitcount=0, no frame_done.
REQ-027 Without events, parallelout and bitcount SHALL hold.

Reset
REQ-028 reset high at a clock edge SHALL clear synchronizers, debounce counters, conditioned values, edge pulses, parallelout, bitcount, frame_done to 0.
REQ-029 reset SHALL override pending events and in-progress debounce or frame; reset mid-frame discards partial bitcount.
REQ-030 A raw input held high through reset release SHALL be re-debounced and produce an event per REQ-018.

Verification (WIDTH=8, WAIT=3)
REQ-031 Reset; load_data=0xA5; btn_load high 10 cycles -> parallelout=0xA5 at edge 6 after rise, bitcount=0, serialout=1 (mode 00).
REQ-032 From 0xA5, mode 00, sw_data=0, 8 clean sw_clk pulses -> 0x4A,0x94,0x28,0x50,0xA0,0x40,0x80,0x00; frame_done one cycle after 8th shift; bitcount=0.
REQ-033 From 0xA5, mode 11, 8 sw_clk pulses -> first 0xD2, final 0xA5, serialout=1 at end, one frame_done pulse.
REQ-034 btn_load high for 2 cycles only -> no load event, parallelout unchanged.
REQ-035 btn_load and sw_clk rising simultaneously -> parallelout=load_data, bitcount=0, frame_done stays 0.
REQ-036 reset after 3 shifts -> parallelout=0x00, bitcount=0, frame_done=0 next cycle; no stale event after release.

Source files
------------

// File: rtl/conditioned_shifter.sv
// Shift register driven by debounced button/switch inputs: each raw input is
// synchronized, debounced, edge-detected, then feeds a load/shift/rotate datapath.
module conditioned_shifter #(
   parameter int WIDTH = 8,
   parameter int WAIT  = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     btn_load,
   input  logic                     sw_clk,
   input  logic                     sw_data,
   input  logic [1:0]               mode,
   input  logic [WIDTH-1:0]         load_data,
   output logic [WIDTH-1:0]         parallelout,
   output logic                     serialout,
   output logic [$clog2(WIDTH)-1:0] bitcount,
   output logic                     frame_done
);

   localparam int BW = $clog2(WIDTH);
   localparam int CW = (WAIT > 1) ? $clog2(WAIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WAIT - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [BW-1:0] BC_LAST  = BW'(WIDTH - 1);
   localparam logic [BW-1:0] BC_ONE   = BW'(1);

   // bit 0: btn_load, bit 1: sw_clk, bit 2: sw_data
   logic [2:0]    raw;
   logic [2:0]    sync1;
   logic [2:0]    sync2;
   logic [2:0]    cond;
   logic [2:0]    cond_d;
   logic [CW-1:0] cnt [3];
   logic          load_evt;
   logic          shift_evt;
   logic [WIDTH-1:0] shifted;

   assign raw = {sw_data, sw_clk, btn_load};

   // Counter holds WAIT-1 on the last mismatching cycle, so the flip lands on
   // the edge where the run of mismatches reaches WAIT.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1     <= '0;
         sync2     <= '0;
         cond      <= '0;
         cond_d    <= '0;
         load_evt  <= 1'b0;
         shift_evt <= 1'b0;
         for (int i = 0; i < 3; i++) cnt[i] <= '0;
      end else begin
         sync1     <= raw;
         sync2     <= sync1;
         cond_d    <= cond;
         load_evt  <= cond[0] & ~cond_d[0];
         shift_evt <= cond[1] & ~cond_d[1];
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] != cond[i]) begin
               if (cnt[i] == CNT_LAST) begin
                  cond[i] <= ~cond[i];
                  cnt[i]  <= '0;
               end else begin
                  cnt[i]  <= cnt[i] + CNT_ONE;
               end
            end else begin
               cnt[i] <= '0;
            end
         end
      end
   end

   always_comb begin
      shifted = parallelout;
      case (mode)
         2'b00: shifted = {parallelout[WIDTH-2:0], cond[2]};
         2'b01: shifted = {cond[2], parallelout[WIDTH-1:1]};
         2'b10: shifted = {parallelout[WIDTH-2:0], parallelout[WIDTH-1]};
         2'b11: shifted = {parallelout[0], parallelout[WIDTH-1:1]};
         default: shifted = parallelout;
      endcase
   end

   // Load has priority: a coincident shift is dropped and never completes a frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         parallelout <= '0;
         bitcount    <= '0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (load_evt) begin
            parallelout <= load_data;
            bitcount    <= '0;
         end else if (shift_evt) begin
            parallelout <= shifted;
            if (bitcount == BC_LAST) begin
               bitcount   <= '0;
               frame_done <= 1'b1;
            end else begin
               bitcount <= bitcount + BC_ONE;
            end
         end
      end
   end

   assign serialout = mode[0] ? parallelout[0] : parallelout[WIDTH-1];

endmodule

// File: tb/tb_conditioned_shifter.sv
// Directed bench for conditioned_shifter (WIDTH=8, WAIT=3): load, shift,
// rotate, glitch rejection, load/shift collision and reset behaviour.
module tb_conditioned_shifter;

   logic       clk;
   logic       reset;
   logic       btn_load;
   logic       sw_clk;
   logic       sw_data;
   logic [1:0] mode;
   logic [7:0] load_data;
   logic [7:0] parallelout;
   logic       serialout;
   logic [2:0] bitcount;
   logic       frame_done;

   int checks = 0;
   int errors = 0;
   int fd_cnt = 0;

   conditioned_shifter #(.WIDTH(8), .WAIT(3)) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_load    (btn_load),
      .sw_clk      (sw_clk),
      .sw_data     (sw_data),
      .mode        (mode),
      .load_data   (load_data),
      .parallelout (parallelout),
      .serialout   (serialout),
      .bitcount    (bitcount),
      .frame_done  (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (frame_done) fd_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // raw rise sampled at edge N, register must still hold at N+5 and update at N+6
   task automatic shift_evt(input logic [7:0] prev, input logic [7:0] exp_po,
                            input logic [2:0] exp_bc, input logic exp_fd);
      @(negedge clk); sw_clk = 1'b1;
      repeat (6) @(posedge clk);
      #1 check("shift_hold", parallelout, prev);
      @(posedge clk);
      #1 check("shift_po", parallelout, exp_po);
      check("shift_bc", bitcount, exp_bc);
      check("shift_fd", frame_done, exp_fd);
      @(posedge clk);
      #1 check("fd_one_cycle", frame_done, 1'b0);
      @(negedge clk); sw_clk = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic load_evt(input logic [7:0] prev, input logic [7:0] val);
      @(negedge clk); load_data = val; btn_load = 1'b1;
      repeat (6) @(posedge clk);
      #1 check("load_hold", parallelout, prev);
      @(posedge clk);
      #1 check("load_po", parallelout, val);
      check("load_bc", bitcount, 3'd0);
      repeat (3) @(negedge clk);
      btn_load = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   logic [7:0] exp_l [8];
   logic [7:0] exp_r [8];
   logic [7:0] exp_s [7];

   initial begin
      exp_l = '{8'h4A, 8'h94, 8'h28, 8'h50, 8'hA0, 8'h40, 8'h80, 8'h00};
      exp_r = '{8'hD2, 8'h69, 8'hB4, 8'h5A, 8'h2D, 8'h96, 8'h4B, 8'hA5};
      exp_s = '{8'h4B, 8'h97, 8'h2F, 8'h5F, 8'hBF, 8'h7F, 8'hFF};

      reset = 1'b1; btn_load = 1'b0; sw_clk = 1'b0; sw_data = 1'b0;
      mode = 2'b00; load_data = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_po", parallelout, 8'h00);
      check("rst_bc", bitcount, 3'd0);
      check("rst_fd", frame_done, 1'b0);
      check("rst_so", serialout, 1'b0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // load 0xA5, mode 00
      load_evt(8'h00, 8'hA5);
      check("load_so", serialout, 1'b1);

      // shift-left 8 times with sw_data=0
      for (int i = 0; i < 8; i++)
         shift_evt(i == 0 ? 8'hA5 : exp_l[i-1], exp_l[i], 3'((i + 1) % 8), i == 7);
      check("frame1_cnt", fd_cnt, 1);
      check("frame1_bc", bitcount, 3'd0);

      // rotate-right 8 times
      load_evt(8'h00, 8'hA5);
      mode = 2'b11;
      for (int i = 0; i < 8; i++)
         shift_evt(i == 0 ? 8'hA5 : exp_r[i-1], exp_r[i], 3'((i + 1) % 8), i == 7);
      check("rotr_so", serialout, 1'b1);
      check("frame2_cnt", fd_cnt, 2);

      // short glitches on btn_load and sw_clk are rejected
      mode = 2'b00; load_data = 8'h3C;
      @(negedge clk); btn_load = 1'b1; sw_clk = 1'b1;
      repeat (2) @(negedge clk);
      btn_load = 1'b0; sw_clk = 1'b0;
      repeat (10) @(negedge clk);
      check("glitch_po", parallelout, 8'hA5);
      check("glitch_bc", bitcount, 3'd0);

      // 7 shifts with sw_data=1, then load and shift collide at bitcount 7
      sw_data = 1'b1;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 7; i++)
         shift_evt(i == 0 ? 8'hA5 : exp_s[i-1], exp_s[i], 3'(i + 1), 1'b0);
      @(negedge clk); load_data = 8'h3C; btn_load = 1'b1; sw_clk = 1'b1;
      repeat (7) @(posedge clk);
      #1 check("both_po", parallelout, 8'h3C);
      check("both_bc", bitcount, 3'd0);
      check("both_fd", frame_done, 1'b0);
      @(negedge clk); btn_load = 1'b0; sw_clk = 1'b0;
      repeat (8) @(negedge clk);
      check("both_fd_cnt", fd_cnt, 2);

      // reset mid-frame
      shift_evt(8'h3C, 8'h79, 3'd1, 1'b0);
      shift_evt(8'h79, 8'hF3, 3'd2, 1'b0);
      shift_evt(8'hF3, 8'hE7, 3'd3, 1'b0);
      @(negedge clk); reset = 1'b1;
      @(negedge clk);
      check("midrst_po", parallelout, 8'h00);
      check("midrst_bc", bitcount, 3'd0);
      check("midrst_fd", frame_done, 1'b0);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      check("stale_po", parallelout, 8'h00);
      check("stale_bc", bitcount, 3'd0);
      check("stale_fd_cnt", fd_cnt, 2);

      // sw_clk held high through reset release is re-debounced
      sw_clk = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      repeat (6) @(posedge clk);
      #1 check("rerel_hold", parallelout, 8'h00);
      @(posedge clk);
      #1 check("rerel_po", parallelout, 8'h01);
      check("rerel_bc", bitcount, 3'd1);
      @(negedge clk); sw_clk = 1'b0;
      repeat (8) @(negedge clk);

      // rotate-left ignores sw_data
      mode = 2'b10;
      shift_evt(8'h01, 8'h02, 3'd2, 1'b0);
      check("rotl_so", serialout, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
